// File: rtl/alu_issue_unit_if.sv
// Bundle of the alu_issue_unit handshake and bus signals: the instruction
// port, the external register load port, the ALU operand/control bus, and
// the result port.
// The slave modport is the issue unit's view; the master modport is the view
// of the SP core or bench that drives the issue unit.
interface alu_issue_unit_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
);
  // Instruction issue port
  logic              ins_valid;
  logic              ins_ready;
  logic [3:0]        ins_op;
  logic [REG_AW-1:0] ins_rd;
  logic [REG_AW-1:0] ins_ra;
  logic [REG_AW-1:0] ins_rb;
  logic [REG_AW-1:0] ins_rc;
  logic              ins_pred;

  // External register load port
  logic              load_en;
  logic [REG_AW-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  // ALU operand/control bus and combinational ALU return
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_c;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_out;
  logic              alu_p;

  // Result port
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [REG_AW-1:0] res_rd;
  logic              res_p;
  logic              res_skipped;
  logic              pred_out;

  modport slave (
    input  ins_valid, ins_op, ins_rd, ins_ra, ins_rb, ins_rc, ins_pred,
    output ins_ready,
    input  load_en, load_addr, load_data,
    output alu_a, alu_b, alu_c, alu_ctrl,
    input  alu_out, alu_p,
    output res_valid,
    input  res_ready,
    output res_data, res_rd, res_p, res_skipped, pred_out
  );

  modport master (
    output ins_valid, ins_op, ins_rd, ins_ra, ins_rb, ins_rc, ins_pred,
    input  ins_ready,
    output load_en, load_addr, load_data,
    input  alu_a, alu_b, alu_c, alu_ctrl,
    output alu_out, alu_p,
    input  res_valid,
    output res_ready,
    input  res_data, res_rd, res_p, res_skipped, pred_out
  );
endinterface

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: accepts one instruction at a time and runs it through the
// SP-core ALU.
// Operation of one instruction:
//   - Read the three source operands serially through a single register file
//     read port.
//   - Drive the registered ALU bus.
//   - Capture the ALU result and predicate, and write the result back.
//   - Hold the result on a valid/ready response port.
// Register 0 always reads as zero and ignores writes.
// Optional feature macro: ALU_ISSUE_PRED_EXEC_EN.
//   - When the macro is defined, a predicated instruction issued while the
//     predicate register is 0 has its writeback suppressed, and it reports
//     res_skipped.
//   - When the macro is undefined, ins_pred is ignored and every instruction
//     writes back.
module alu_issue_unit #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned REG_AW   = 3
) (
  input  logic           clock,
  input  logic           reset_n,
  alu_issue_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    RD_C = 3'd3,
    EXEC = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Latched instruction fields
  logic [3:0]        op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [REG_AW-1:0] ra_q, ra_d;
  logic [REG_AW-1:0] rb_q, rb_d;
  logic [REG_AW-1:0] rc_q, rc_d;
  logic              ins_pred_q, ins_pred_d;

  // Operand staging. A and B wait here so that the ALU bus changes only on
  // entry to EXEC.
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;

  // Registered ALU bus; it holds its value outside EXEC.
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [DATA_W-1:0] alu_c_q, alu_c_d;
  logic [3:0]        alu_ctrl_q, alu_ctrl_d;

  // Captured response and predicate register
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [REG_AW-1:0] res_rd_q, res_rd_d;
  logic              res_p_q, res_p_d;
  logic              res_skipped_q, res_skipped_d;
  logic              pred_reg_q, pred_reg_d;

  // Register file
  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];

  logic [REG_AW-1:0] rd_idx;
  logic [DATA_W-1:0] rf_rdata;
  logic              wb_skip;

`ifdef ALU_ISSUE_PRED_EXEC_EN
  assign wb_skip = ins_pred_q && !pred_reg_q;
`else
  logic pred_unused;
  assign pred_unused = ins_pred_q;
  assign wb_skip     = 1'b0;
`endif

  // Single read port: the state selects which source index is being fetched.
  always_comb begin
    rd_idx = ra_q;
    case (state_q)
      RD_B:    rd_idx = rb_q;
      RD_C:    rd_idx = rc_q;
      default: rd_idx = ra_q;
    endcase
  end

  assign rf_rdata = (rd_idx == '0) ? '0 : rf_q[rd_idx];

  assign bus.ins_ready   = (state_q == IDLE) && !bus.load_en;
  assign bus.res_valid   = (state_q == RESP);
  assign bus.res_data    = res_data_q;
  assign bus.res_rd      = res_rd_q;
  assign bus.res_p       = res_p_q;
  assign bus.res_skipped = res_skipped_q;
  assign bus.pred_out    = pred_reg_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_c       = alu_c_q;
  assign bus.alu_ctrl    = alu_ctrl_q;

  // Next-state, operand fetch, ALU bus load, writeback and load-port logic
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    rd_d          = rd_q;
    ra_d          = ra_q;
    rb_d          = rb_q;
    rc_d          = rc_q;
    ins_pred_d    = ins_pred_q;
    opa_d         = opa_q;
    opb_d         = opb_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_c_d       = alu_c_q;
    alu_ctrl_d    = alu_ctrl_q;
    res_data_d    = res_data_q;
    res_rd_d      = res_rd_q;
    res_p_d       = res_p_q;
    res_skipped_d = res_skipped_q;
    pred_reg_d    = pred_reg_q;
    rf_d          = rf_q;

    case (state_q)
      IDLE: begin
        if (bus.load_en) begin
          if (bus.load_addr != '0) begin
            rf_d[bus.load_addr] = bus.load_data;
          end
        end else if (bus.ins_valid) begin
          op_d       = bus.ins_op;
          rd_d       = bus.ins_rd;
          ra_d       = bus.ins_ra;
          rb_d       = bus.ins_rb;
          rc_d       = bus.ins_rc;
          ins_pred_d = bus.ins_pred;
          state_d    = RD_A;
        end
      end
      RD_A: begin
        opa_d   = rf_rdata;
        state_d = RD_B;
      end
      RD_B: begin
        opb_d   = rf_rdata;
        state_d = RD_C;
      end
      // C goes straight onto the bus alongside the staged A/B, so all
      // operands and the control code change together on entry to EXEC.
      RD_C: begin
        alu_a_d    = opa_q;
        alu_b_d    = opb_q;
        alu_c_d    = rf_rdata;
        alu_ctrl_d = op_q;
        state_d    = EXEC;
      end
      EXEC: begin
        res_data_d    = bus.alu_out;
        res_p_d       = bus.alu_p;
        res_rd_d      = rd_q;
        res_skipped_d = wb_skip;
        if (!wb_skip) begin
          if (rd_q != '0) begin
            rf_d[rd_q] = bus.alu_out;
          end
          pred_reg_d = bus.alu_p;
        end
        state_d = RESP;
      end
      RESP: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and register file storage with asynchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      op_q          <= '0;
      rd_q          <= '0;
      ra_q          <= '0;
      rb_q          <= '0;
      rc_q          <= '0;
      ins_pred_q    <= 1'b0;
      opa_q         <= '0;
      opb_q         <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_c_q       <= '0;
      alu_ctrl_q    <= 4'b0000;
      res_data_q    <= '0;
      res_rd_q      <= '0;
      res_p_q       <= 1'b0;
      res_skipped_q <= 1'b0;
      pred_reg_q    <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      rd_q          <= rd_d;
      ra_q          <= ra_d;
      rb_q          <= rb_d;
      rc_q          <= rc_d;
      ins_pred_q    <= ins_pred_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_c_q       <= alu_c_d;
      alu_ctrl_q    <= alu_ctrl_d;
      res_data_q    <= res_data_d;
      res_rd_q      <= res_rd_d;
      res_p_q       <= res_p_d;
      res_skipped_q <= res_skipped_d;
      pred_reg_q    <= pred_reg_d;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit.
// The ALU stub returns a + b + c, with the predicate equal to bit 0 of the
// result. Expected responses come from a bench-side register file model and
// are queued at issue time.
module tb_alu_issue_unit;

  logic clock;
  logic reset_n;

  int checks;
  int errors;

  alu_issue_unit_if #(.DATA_W(16), .REG_AW(3)) bus ();

  alu_issue_unit #(
    .DATA_W  (16),
    .NUM_REGS(8),
    .REG_AW  (3)
  ) u_dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  assign bus.alu_out = bus.alu_a + bus.alu_b + bus.alu_c;
  assign bus.alu_p   = bus.alu_out[0];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  rd;
    logic        p;
    logic        skipped;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mdl_rf [8];
  logic        mdl_pred;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Starts and ends on a falling edge.
  task automatic load(input logic [2:0] addr, input logic [15:0] data);
    bus.load_en   = 1'b1;
    bus.load_addr = addr;
    bus.load_data = data;
    @(posedge clock);
    #1;
    bus.load_en = 1'b0;
    if (addr != 3'd0) mdl_rf[addr] = data;
    @(negedge clock);
  endtask

  // Issue one instruction, check latency and bus, hold back-pressure for
  // 'hold' cycles, then compare against the queued expectation.
  // Starts and ends on a falling edge.
  task automatic run(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] ra,
                     input logic [2:0] rb, input logic [2:0] rc, input logic pred,
                     input int hold);
    exp_t        e;
    exp_t        got;
    logic [15:0] sum;
    logic        sk;
    int          n;
    sum = mdl_rf[ra] + mdl_rf[rb] + mdl_rf[rc];
`ifdef ALU_ISSUE_PRED_EXEC_EN
    sk = pred && !mdl_pred;
`else
    sk = 1'b0;
`endif
    e.data    = sum;
    e.rd      = rd;
    e.p       = sum[0];
    e.skipped = sk;
    sb.push_back(e);
    if (!sk) begin
      if (rd != 3'd0) mdl_rf[rd] = sum;
      mdl_pred = sum[0];
    end

    bus.ins_op    = op;
    bus.ins_rd    = rd;
    bus.ins_ra    = ra;
    bus.ins_rb    = rb;
    bus.ins_rc    = rc;
    bus.ins_pred  = pred;
    bus.ins_valid = 1'b1;
    #1;
    n = 0;
    while (!bus.ins_ready && n < 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("ins_ready_idle", {31'd0, bus.ins_ready}, 32'd1);
    @(posedge clock);
    #1;
    bus.ins_valid = 1'b0;

    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 4) chk("alu_ctrl_exec", {28'd0, bus.alu_ctrl}, {28'd0, op});
    end while (!bus.res_valid && n < 20);
    chk("res_latency", n, 5);
    chk("busy_ins_ready", {31'd0, bus.ins_ready}, 32'd0);
    chk("alu_ctrl_hold", {28'd0, bus.alu_ctrl}, {28'd0, op});

    got = '0;
    if (sb.size() > 0) got = sb.pop_front();
    chk("res_data", {16'd0, bus.res_data}, {16'd0, got.data});
    chk("res_rd", {29'd0, bus.res_rd}, {29'd0, got.rd});
    chk("res_p", {31'd0, bus.res_p}, {31'd0, got.p});
    chk("res_skipped", {31'd0, bus.res_skipped}, {31'd0, got.skipped});
    chk("pred_out", {31'd0, bus.pred_out}, {31'd0, mdl_pred});

    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("bp_valid", {31'd0, bus.res_valid}, 32'd1);
      chk("bp_data", {16'd0, bus.res_data}, {16'd0, got.data});
      chk("bp_ins_ready", {31'd0, bus.ins_ready}, 32'd0);
    end

    bus.res_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.res_ready = 1'b0;
    @(negedge clock);
    chk("res_valid_drop", {31'd0, bus.res_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 8; i++) mdl_rf[i] = 16'h0000;
    mdl_pred      = 1'b0;
    bus.ins_valid = 1'b0;
    bus.ins_op    = 4'h0;
    bus.ins_rd    = 3'd0;
    bus.ins_ra    = 3'd0;
    bus.ins_rb    = 3'd0;
    bus.ins_rc    = 3'd0;
    bus.ins_pred  = 1'b0;
    bus.load_en   = 1'b0;
    bus.load_addr = 3'd0;
    bus.load_data = 16'h0000;
    bus.res_ready = 1'b0;
    reset_n       = 1'b0;

    #2;
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    chk("rst_res_data", {16'd0, bus.res_data}, 32'd0);
    chk("rst_pred_out", {31'd0, bus.pred_out}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Basic issue with 10 cycles of back-pressure
    load(3'd1, 16'h0019);
    load(3'd2, 16'h0002);
    load(3'd3, 16'h0005);
    run(4'h1, 3'd4, 3'd1, 3'd2, 3'd3, 1'b0, 10);
    // Follow-up reads r4 (0x0020) and gives an odd sum
    run(4'h2, 3'd2, 3'd4, 3'd1, 3'd0, 1'b0, 0);
    // Predicated instruction with predicate register = 1 always writes back
    run(4'h3, 3'd6, 3'd2, 3'd0, 3'd0, 1'b1, 0);

    // Load has priority over issue in IDLE
    bus.ins_op    = 4'h7;
    bus.ins_rd    = 3'd7;
    bus.ins_ra    = 3'd1;
    bus.ins_rb    = 3'd1;
    bus.ins_rc    = 3'd1;
    bus.ins_valid = 1'b1;
    bus.load_en   = 1'b1;
    bus.load_addr = 3'd6;
    bus.load_data = 16'h0100;
    #1;
    chk("load_prio_ready", {31'd0, bus.ins_ready}, 32'd0);
    @(posedge clock);
    #1;
    bus.load_en   = 1'b0;
    bus.ins_valid = 1'b0;
    mdl_rf[6] = 16'h0100;
    @(negedge clock);
    chk("load_prio_idle", {31'd0, bus.res_valid}, 32'd0);
    run(4'h4, 3'd7, 3'd6, 3'd0, 3'd0, 1'b0, 0);

    // Register 0 ignores loads and writebacks but the result is still reported
    load(3'd0, 16'hFFFF);
    run(4'h5, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 0);
    run(4'h5, 3'd0, 3'd1, 3'd2, 3'd0, 1'b0, 0);
    run(4'h6, 3'd3, 3'd0, 3'd0, 3'd0, 1'b0, 0);
    // Aliased sources and destination
    run(4'h8, 3'd2, 3'd2, 3'd2, 3'd2, 1'b0, 0);

    // Reset during RD_B
    bus.ins_op    = 4'h9;
    bus.ins_rd    = 3'd5;
    bus.ins_ra    = 3'd1;
    bus.ins_rb    = 3'd2;
    bus.ins_rc    = 3'd3;
    bus.ins_pred  = 1'b0;
    bus.ins_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.ins_valid = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_alu_a", {16'd0, bus.alu_a}, 32'd0);
    chk("mid_rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    chk("mid_rst_res_data", {16'd0, bus.res_data}, 32'd0);
    chk("mid_rst_res_rd", {29'd0, bus.res_rd}, 32'd0);
    chk("mid_rst_pred_out", {31'd0, bus.pred_out}, 32'd0);
    for (int i = 0; i < 8; i++) mdl_rf[i] = 16'h0000;
    mdl_pred = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("mid_rst_idle", {31'd0, bus.ins_ready}, 32'd1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.res_valid) n++;
    end
    chk("mid_rst_no_resp", n, 0);
    // Register file cleared, including the aborted destination
    run(4'h1, 3'd4, 3'd1, 3'd5, 3'd6, 1'b0, 0);

    // Predication: predicate register = 0 after an even result
    load(3'd1, 16'h0004);
    load(3'd2, 16'h0006);
    load(3'd5, 16'h0033);
    run(4'h1, 3'd3, 3'd1, 3'd2, 3'd0, 1'b0, 0);
    run(4'h1, 3'd5, 3'd1, 3'd1, 3'd1, 1'b1, 0);
    run(4'h2, 3'd6, 3'd5, 3'd0, 3'd0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
